// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, one bit per clock LSB first, with
//               valid/ready handshakes on operands and result.
//               Optional signed-overflow flag via `SERIAL_SUB_OVF_EN`.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_ready_q;
  logic             res_valid_q;
  logic             busy_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic             sub_bit;
  logic             sub_bo;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] diff_d;

  // One full-subtractor cell applied to the current LSBs and the ripple borrow
  assign sub_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign sub_bo  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  assign a_d    = {1'b0, a_q[WIDTH-1:1]};
  assign b_d    = {1'b0, b_q[WIDTH-1:1]};
  assign diff_d = {sub_bit, diff_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      diff_q        <= '0;
      br_q          <= 1'b0;
      cnt_q         <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_q           <= a_in;
            b_q           <= b_in;
            br_q          <= bin_in;
            cnt_q         <= '0;
            state_q       <= S_SHIFT;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        S_SHIFT: begin
          a_q    <= a_d;
          b_q    <= b_d;
          diff_q <= diff_d;
          br_q   <= sub_bo;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB differs from borrow out: signed overflow
            ovf_q       <= br_q ^ sub_bo;
`endif
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_q       <= S_IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign diff_out    = diff_q;
  assign bout_out    = br_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_out     = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH 8 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       sv8, sr8, bin8, bo8, rv8, rr8, busy8;
  logic [7:0] a8, b8, d8;
  logic       sv4, sr4, bin4, bo4, rv4, rr4, busy4;
  logic [3:0] a4, b4, d4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv8),
    .start_ready (sr8),
    .a_in        (a8),
    .b_in        (b8),
    .bin_in      (bin8),
    .diff_out    (d8),
    .bout_out    (bo8),
    .res_valid   (rv8),
    .res_ready   (rr8),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_out     (ovf8),
`endif
    .busy        (busy8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv4),
    .start_ready (sr4),
    .a_in        (a4),
    .b_in        (b4),
    .bin_in      (bin4),
    .diff_out    (d4),
    .bout_out    (bo4),
    .res_valid   (rv4),
    .res_ready   (rr4),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_out     (ovf4),
`endif
    .busy        (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic void model(input int w, input int a, input int b, input int bin,
                                output int diff, output int bout, output int ovf);
    int r, sa, sb, sr, half;
    half = 1 << (w - 1);
    r    = a - b - bin;
    diff = r & ((1 << w) - 1);
    bout = (r < 0) ? 1 : 0;
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    sr   = sa - sb - bin;
    ovf  = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    chk("start_ready8", 32'(sr8), 32'd1);
    sv8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(posedge clk);
    @(negedge clk);
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    chk("busy8", 32'(busy8), 32'd1);
  endtask

  task automatic wait_res8();
    int lat = 0;
    while (rv8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency8", 32'(lat), 32'd8);
  endtask

  task automatic check_res8(input int a, input int b, input int bin);
    int ed, eb, eo;
    model(8, a, b, bin, ed, eb, eo);
    chk("diff8", 32'(d8), 32'(ed));
    chk("bout8", 32'(bo8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf8", 32'(ovf8), 32'(eo));
`endif
  endtask

  task automatic ack8();
    rr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr8 = 1'b0;
    chk("ack_valid8", 32'(rv8), 32'd0);
    chk("ack_ready8", 32'(sr8), 32'd1);
    chk("ack_busy8", 32'(busy8), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ed, eb, eo, lat;
    logic [7:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0;
    sv8 = 0; a8 = 0; b8 = 0; bin8 = 0; rr8 = 0;
    sv4 = 0; a4 = 0; b4 = 0; bin4 = 0; rr4 = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rv8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_diff", 32'(d8), 32'd0);
    chk("rst_bout", 32'(bo8), 32'd0);
    chk("rst_ready", 32'(sr8), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      start8(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_res8();
      chk("tbl_diff", 32'(d8), 32'(vecs[i].diff));
      chk("tbl_bout", 32'(bo8), 32'(vecs[i].bout));
`ifdef SERIAL_SUB_OVF_EN
      chk("tbl_ovf", 32'(ovf8), 32'(vecs[i].ovf));
`endif
      ack8();
    end

    // Backpressure with a competing start request
    start8(8'h33, 8'h44, 1'b1);
    wait_res8();
    check_res8(8'h33, 8'h44, 1);
    sv8 = 1'b1; a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rv8), 32'd1);
      chk("bp_ready", 32'(sr8), 32'd0);
      check_res8(8'h33, 8'h44, 1);
    end
    rr8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr8 = 1'b0;
    chk("bp_rel_valid", 32'(rv8), 32'd0);
    chk("bp_rel_ready", 32'(sr8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    sv8 = 1'b0; a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1;
    wait_res8();
    check_res8(8'hC3, 8'h3C, 0);
    ack8();

    // res_ready held high: single-cycle valid pulse, result held in IDLE
    rr8 = 1'b1;
    start8(8'hA5, 8'h5A, 1'b0);
    wait_res8();
    check_res8(8'hA5, 8'h5A, 0);
    @(negedge clk);
    chk("pulse_valid", 32'(rv8), 32'd0);
    chk("pulse_ready", 32'(sr8), 32'd1);
    check_res8(8'hA5, 8'h5A, 0);
    rr8 = 1'b0;

    // Asynchronous reset in the third SHIFT cycle
    start8(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rv8), 32'd0);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_diff", 32'(d8), 32'd0);
    chk("arst_bout", 32'(bo8), 32'd0);
    chk("arst_ready", 32'(sr8), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    chk("arst_ovf", 32'(ovf8), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("arst_no_valid", 32'(rv8), 32'd0);
    end
    start8(8'h9C, 8'h4D, 1'b1);
    wait_res8();
    check_res8(8'h9C, 8'h4D, 1);
    ack8();

    // Randomized 8-bit operations with random result stalls
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      start8(ra, rb, rbin);
      wait_res8();
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold", 32'(rv8), 32'd1);
      end
      check_res8(int'(ra), int'(rb), int'(rbin));
      ack8();
    end

    // Exhaustive WIDTH=4, back-to-back, random stalls
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bin = 0; bin < 2; bin++) begin
          chk("ex_ready4", 32'(sr4), 32'd1);
          sv4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin);
          @(posedge clk);
          @(negedge clk);
          sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
          lat = 0;
          while (rv4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
          end
          chk("ex_latency4", 32'(lat), 32'd4);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          model(4, a, b, bin, ed, eb, eo);
          chk("ex_diff4", 32'(d4), 32'(ed));
          chk("ex_bout4", 32'(bo4), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
          chk("ex_ovf4", 32'(ovf4), 32'(eo));
`endif
          rr4 = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rr4 = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
